// File: rtl/tnn_pkg.sv
// Shared types and helper functions for the temporal neural network gamma/STDP blocks.
package tnn_pkg;

    typedef enum logic [2:0] {
        NONE,
        CAPTURE,
        BACKOFF,
        SEARCH,
        MINUS
    } stdp_case_e;

    function automatic int unsigned wmax_of(input int unsigned wres);
        return (32'd1 << wres) - 32'd1;
    endfunction

    function automatic int unsigned phase_w(input int unsigned len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/spike_pulse_gen.sv
// Per-synapse input capture, WMAX-wide spike pulse generator and STDP decision.
module spike_pulse_gen
    import tnn_pkg::*;
#(
    parameter int unsigned WRES = 3,
    parameter int unsigned CW   = 5
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          clr,
    input  logic          in_win,
    input  logic          strobe,
    input  logic          decide,
    input  logic          out_cap,
    input  logic [CW-1:0] t_out,
    input  logic [CW-1:0] gamma_cnt,
    output logic          spike_pulse,
    output logic          inc,
    output logic          dec
);

    localparam int unsigned WMAX = wmax_of(WRES);

    logic            cap_q,   cap_d;
    logic [CW-1:0]   t_in_q,  t_in_d;
    logic [WRES-1:0] cnt_q,   cnt_d;
    logic            pulse_q, pulse_d;
    logic            inc_q,   inc_d;
    logic            dec_q,   dec_d;
    logic            accept;
    stdp_case_e      stdp_case;

    always_comb begin
        accept    = in_win & strobe & ~cap_q;
        cap_d     = cap_q;
        t_in_d    = t_in_q;
        cnt_d     = cnt_q;
        stdp_case = NONE;

        if (clr) begin
            cap_d = 1'b0;
        end else if (accept) begin
            cap_d  = 1'b1;
            t_in_d = gamma_cnt;
        end

        // Pulse is high for the WMAX cycles after capture; counter value 1 marks the last one.
        if (accept) begin
            cnt_d = WRES'(WMAX);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WRES'(1);
        end
        pulse_d = accept | (cnt_q > WRES'(1));

        if (cap_q && out_cap) begin
            stdp_case = (t_in_q <= t_out) ? CAPTURE : BACKOFF;
        end else if (cap_q) begin
            stdp_case = SEARCH;
        end else if (out_cap) begin
            stdp_case = MINUS;
        end

        inc_d = decide & ((stdp_case == CAPTURE) | (stdp_case == SEARCH));
        dec_d = decide & ((stdp_case == BACKOFF) | (stdp_case == MINUS));
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            cap_q   <= 1'b0;
            t_in_q  <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            cap_q   <= cap_d;
            t_in_q  <= t_in_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
        end
    end

    assign spike_pulse = pulse_q;
    assign inc         = inc_q;
    assign dec         = dec_q;

endmodule

// File: rtl/gamma_stdp_ctrl.sv
// Gamma-cycle sequencer: phase counter, gamma reset pulse, output spike capture and per-synapse STDP.
module gamma_stdp_ctrl
    import tnn_pkg::*;
#(
    parameter int unsigned P         = 8,
    parameter int unsigned WRES      = 3,
    parameter int unsigned GAMMA_LEN = 32
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic [P-1:0]                    in_strobe,
    input  logic                            out_spike,
    input  logic                            stdp_en,
    output logic                            grst,
    output logic [P-1:0]                    spike_pulse,
    output logic [P-1:0]                    inc,
    output logic [P-1:0]                    dec,
    output logic [phase_w(GAMMA_LEN)-1:0]   gamma_cnt
);

    localparam int unsigned CW     = phase_w(GAMMA_LEN);
    localparam int unsigned WMAX   = wmax_of(WRES);
    localparam int unsigned LAST   = GAMMA_LEN - 1;
    localparam int unsigned IN_HI  = GAMMA_LEN - 1 - WMAX;
    localparam int unsigned OUT_HI = GAMMA_LEN - 2;

    logic [CW-1:0] cnt_q,     cnt_d;
    logic          grst_q,    grst_d;
    logic          out_cap_q, out_cap_d;
    logic [CW-1:0] t_out_q,   t_out_d;
    logic          at_zero;
    logic          at_last;
    logic          in_win;
    logic          out_win;
    logic          decide;

    always_comb begin
        at_zero   = (cnt_q == '0);
        at_last   = (cnt_q == CW'(LAST));
        cnt_d     = at_last ? '0 : cnt_q + CW'(1);
        grst_d    = at_last;
        in_win    = !at_zero && (cnt_q <= CW'(IN_HI));
        out_win   = !at_zero && (cnt_q <= CW'(OUT_HI));
        decide    = at_last & stdp_en;
        out_cap_d = out_cap_q;
        t_out_d   = t_out_q;

        // Boundary cycle wipes the previous gamma's output capture.
        if (at_zero) begin
            out_cap_d = 1'b0;
            t_out_d   = '0;
        end else if (out_win && out_spike && !out_cap_q) begin
            out_cap_d = 1'b1;
            t_out_d   = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt_q     <= '0;
            grst_q    <= 1'b0;
            out_cap_q <= 1'b0;
            t_out_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            grst_q    <= grst_d;
            out_cap_q <= out_cap_d;
            t_out_q   <= t_out_d;
        end
    end

    for (genvar i = 0; i < P; i++) begin : g_syn
        spike_pulse_gen #(
            .WRES (WRES),
            .CW   (CW)
        ) u_syn (
            .clk         (clk),
            .rstb        (rstb),
            .clr         (at_zero),
            .in_win      (in_win),
            .strobe      (in_strobe[i]),
            .decide      (decide),
            .out_cap     (out_cap_q),
            .t_out       (t_out_q),
            .gamma_cnt   (cnt_q),
            .spike_pulse (spike_pulse[i]),
            .inc         (inc[i]),
            .dec         (dec[i])
        );
    end

    assign grst      = grst_q;
    assign gamma_cnt = cnt_q;

endmodule
